// File: rtl/lmac_tx_arb_pkg.sv
// Shared types and constants for the LMAC transmit arbiter.
// The optional stall watchdog is enabled with the LMAC_TX_ARB_WDOG_EN macro.
package lmac_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

    localparam int PKT_CNT_W = 16;

    // With both sources eligible, fixed mode always favours s0; round-robin
    // hands the grant to whichever source did not finish the last packet.
    function automatic arb_state_t pick_owner(
        input logic elig0,
        input logic elig1,
        input logic prio_fixed,
        input logic last_s1
    );
        arb_state_t owner;
        owner = ST_IDLE;
        if (elig0 && elig1) begin
            owner = (prio_fixed || last_s1) ? ST_GNT0 : ST_GNT1;
        end else if (elig0) begin
            owner = ST_GNT0;
        end else if (elig1) begin
            owner = ST_GNT1;
        end
        return owner;
    endfunction

endpackage

// File: rtl/lmac_tx_arb_wdog.sv
// Stall watchdog: fires after WDOG_CYC consecutive stalled cycles of the owner.
// Only instantiated when LMAC_TX_ARB_WDOG_EN is defined.
module lmac_tx_arb_wdog #(
    parameter int WDOG_CYC = 1024
) (
    input  logic clk,
    input  logic reset_,
    input  logic stall,
    output logic fire,
    output logic pulse
);

    localparam int CNT_W = $clog2(WDOG_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYC - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt;

    // The cycle that completes the WDOG_CYC-th stall is the one that fires.
    assign fire = stall && (stall_cnt == LIMIT);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stall_cnt <= '0;
            pulse     <= 1'b0;
        end else begin
            pulse <= fire;
            if (!stall || fire) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/lmac_tx_arb.sv
// Two-source packet arbiter feeding the LMAC TX FIFO, with framing checks.
// Define LMAC_TX_ARB_WDOG_EN to build in the owner-stall watchdog.
module lmac_tx_arb
    import lmac_tx_arb_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int USEDW_W   = 13,
    parameter int START_THR = 7936,
    parameter int WDOG_CYC  = 1024
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 s0_valid,
    input  logic [DATA_W-1:0]    s0_data,
    input  logic                 s0_sop,
    input  logic                 s0_eop,
    output logic                 s0_ready,
    input  logic                 s1_valid,
    input  logic [DATA_W-1:0]    s1_data,
    input  logic                 s1_sop,
    input  logic                 s1_eop,
    output logic                 s1_ready,
    input  logic                 arb_en,
    input  logic                 prio_mode,
    output logic                 tx_mac_wr,
    output logic [DATA_W-1:0]    tx_mac_data,
    input  logic                 tx_mac_full,
    input  logic [USEDW_W-1:0]   tx_mac_usedw,
    output logic [1:0]           grant,
    output logic                 err_frm,
    output logic                 wdog_to,
    output logic [PKT_CNT_W-1:0] pkt_cnt0,
    output logic [PKT_CNT_W-1:0] pkt_cnt1
);

    localparam logic [USEDW_W-1:0]   START_LVL = USEDW_W'(START_THR);
    localparam logic [PKT_CNT_W-1:0] CNT_ONE   = PKT_CNT_W'(1);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              last_s1;
    logic              first_word;
    logic              room;
    logic              elig0;
    logic              elig1;
    logic              owner_valid;
    logic              owner_sop;
    logic              owner_eop;
    logic [DATA_W-1:0] owner_data;
    logic              fwd_accept;
    logic              frm_err;
    logic              pkt_done;
    logic              wdog_fire;

    assign room  = (tx_mac_usedw < START_LVL);
    assign elig0 = s0_valid && s0_sop && arb_en && room;
    assign elig1 = s1_valid && s1_sop && arb_en && room;

    // Owner view is kept apart from the FSM so the watchdog can use it
    // without forming a combinational loop through next_state.
    always_comb begin
        owner_valid = 1'b0;
        owner_sop   = 1'b0;
        owner_eop   = 1'b0;
        owner_data  = s0_data;
        case (state)
            ST_GNT0: begin
                owner_valid = s0_valid;
                owner_sop   = s0_sop;
                owner_eop   = s0_eop;
                owner_data  = s0_data;
            end
            ST_GNT1: begin
                owner_valid = s1_valid;
                owner_sop   = s1_sop;
                owner_eop   = s1_eop;
                owner_data  = s1_data;
            end
            default: begin
                owner_valid = 1'b0;
            end
        endcase
    end

`ifdef LMAC_TX_ARB_WDOG_EN
    lmac_tx_arb_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk    (clk),
        .reset_ (reset_),
        .stall  ((state != ST_IDLE) && !owner_valid),
        .fire   (wdog_fire),
        .pulse  (wdog_to)
    );
`else
    assign wdog_fire = 1'b0;
    assign wdog_to   = 1'b0;
`endif

    // In IDLE only non-sop words are taken, and only to be thrown away;
    // the sop word itself is accepted once the grant is in place.
    always_comb begin
        next_state = state;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        fwd_accept = 1'b0;
        frm_err    = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = pick_owner(elig0, elig1, prio_mode, last_s1);
                if (s0_valid && !s0_sop) begin
                    s0_ready = 1'b1;
                    frm_err  = 1'b1;
                end
                if (s1_valid && !s1_sop) begin
                    s1_ready = 1'b1;
                    frm_err  = 1'b1;
                end
            end
            ST_GNT0: begin
                s0_ready = !tx_mac_full;
            end
            ST_GNT1: begin
                s1_ready = !tx_mac_full;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (state == ST_GNT0 || state == ST_GNT1) begin
            fwd_accept = owner_valid && !tx_mac_full;
            if (fwd_accept && owner_sop && !first_word) begin
                frm_err = 1'b1;
            end
            if (fwd_accept && owner_eop) begin
                next_state = ST_IDLE;
                pkt_done   = 1'b1;
            end
            if (wdog_fire) begin
                next_state = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= ST_IDLE;
            last_s1    <= 1'b1;
            first_word <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state != ST_IDLE) begin
                first_word <= 1'b1;
            end else if (fwd_accept) begin
                first_word <= 1'b0;
            end
            if (pkt_done) begin
                last_s1 <= (state == ST_GNT1);
            end
        end
    end

    // Write side is a straight one-cycle register stage of accepted words.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            tx_mac_wr   <= 1'b0;
            tx_mac_data <= '0;
            err_frm     <= 1'b0;
            pkt_cnt0    <= '0;
            pkt_cnt1    <= '0;
        end else begin
            tx_mac_wr <= fwd_accept;
            if (fwd_accept) begin
                tx_mac_data <= owner_data;
            end
            err_frm <= frm_err;
            if (pkt_done && state == ST_GNT0) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_ONE;
            end
            if (pkt_done && state == ST_GNT1) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_ONE;
            end
        end
    end

    always_comb begin
        grant = GNT_NONE;
        case (state)
            ST_GNT0: grant = GNT_S0;
            ST_GNT1: grant = GNT_S1;
            default: grant = GNT_NONE;
        endcase
    end

endmodule
